// File: rtl/byte_pack_fifo4.sv
// Packs DATA_WIDTH-bit elements MSB-first into 4-lane words
// and queues the packed words in a DEPTH-entry FIFO.
module byte_pack_fifo4 #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      write_en,
  input  logic [DATA_WIDTH-1:0]     write_data,
  input  logic                      flush,
  input  logic                      read_en,
  output logic [4*DATA_WIDTH-1:0]   read_data,
  output logic                      read_valid,
  output logic                      full,
  output logic                      empty,
  output logic [$clog2(DEPTH):0]    word_count,
  output logic [1:0]                lane_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int WW = 4 * DATA_WIDTH;

  logic [WW-1:0] mem_q [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    lane_q, lane_d;
  logic [WW-1:0] pack_q, pack_d;
  logic [WW-1:0] rdata_q, rdata_d;
  logic          rv_q, rv_d;

  logic          wr_acc;
  logic          rd_acc;
  logic          commit_full;
  logic          commit_flush;
  logic          commit;
  logic [WW-1:0] placed;

  assign full       = (cnt_q == CW'(DEPTH));
  assign empty      = (cnt_q == '0);
  assign word_count = cnt_q;
  assign lane_count = lane_q;
  assign read_data  = rdata_q;
  assign read_valid = rv_q;

  always_comb begin
    wr_acc = write_en && !full;
    rd_acc = read_en && !empty;

    placed = pack_q;
    for (int i = 0; i < 4; i++) begin
      if (wr_acc && lane_q == 2'(i))
        placed[(3-i)*DATA_WIDTH +: DATA_WIDTH] = write_data;
    end

    // a write that fills the word wins; flush then adds nothing
    commit_full  = wr_acc && (lane_q == 2'd3);
    commit_flush = flush && !full && !commit_full
                   && (wr_acc || lane_q != 2'd0);
    commit       = commit_full || commit_flush;

    pack_d = placed;
    lane_d = lane_q + {1'b0, wr_acc};
    if (commit) begin
      pack_d = '0;
      lane_d = 2'd0;
    end

    wr_ptr_d = wr_ptr_q;
    if (commit)
      wr_ptr_d = wr_ptr_q + 1'b1;

    rd_ptr_d = rd_ptr_q;
    rdata_d  = rdata_q;
    if (rd_acc) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      rdata_d  = mem_q[rd_ptr_q];
    end
    rv_d = rd_acc;

    cnt_d = cnt_q;
    if (commit && !rd_acc)
      cnt_d = cnt_q + 1'b1;
    else if (!commit && rd_acc)
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      lane_q   <= '0;
      pack_q   <= '0;
      rdata_q  <= '0;
      rv_q     <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      lane_q   <= lane_d;
      pack_q   <= pack_d;
      rdata_q  <= rdata_d;
      rv_q     <= rv_d;
    end
  end

  // storage is deliberately left out of reset
  always_ff @(posedge clk) begin
    if (commit)
      mem_q[wr_ptr_q] <= placed;
  end

endmodule

// File: tb/tb_byte_pack_fifo4.sv
// Bench for byte_pack_fifo4: vector table plus hand sequences,
// with packed words checked through an expected-word queue.
module tb_byte_pack_fifo4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        write_en = 1'b0;
  logic [7:0]  write_data = '0;
  logic        flush = 1'b0;
  logic        read_en = 1'b0;
  logic [31:0] read_data;
  logic        read_valid;
  logic        full;
  logic        empty;
  logic [2:0]  word_count;
  logic [1:0]  lane_count;

  byte_pack_fifo4 #(.DATA_WIDTH(8), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .write_en(write_en), .write_data(write_data),
    .flush(flush), .read_en(read_en),
    .read_data(read_data), .read_valid(read_valid),
    .full(full), .empty(empty),
    .word_count(word_count), .lane_count(lane_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [7:0]  wd;
    logic        fl;
    logic        re;
    int          wc;
    int          lc;
    logic        rv;
    logic        push;
    logic [31:0] word;
  } vec_t;

  vec_t        tbl[$];
  logic [31:0] exp_q[$];
  logic [31:0] last_rd;
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input logic we, input logic [7:0] wd,
                      input logic fl, input logic re,
                      input int wc, input int lc, input logic rv);
    logic [31:0] e;
    write_en = we; write_data = wd; flush = fl; read_en = re;
    @(posedge clk);
    #1;
    write_en = 0; write_data = '0; flush = 0; read_en = 0;
    chk("word_count", 32'(word_count), 32'(wc));
    chk("lane_count", 32'(lane_count), 32'(lc));
    chk("full", 32'(full), 32'(wc == 4));
    chk("empty", 32'(empty), 32'(wc == 0));
    chk("read_valid", 32'(read_valid), 32'(rv));
    if (read_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_word", read_data, 32'hxxxxxxxx);
      end else begin
        e = exp_q.pop_front();
        chk("read_data", read_data, e);
        last_rd = e;
      end
    end else begin
      chk("read_data_hold", read_data, last_rd);
    end
  endtask

  initial begin
    last_rd = '0;
    #1 rst = 1'b1;
    #2;
    chk("rst_word_count", 32'(word_count), 0);
    chk("rst_lane_count", 32'(lane_count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_read_valid", 32'(read_valid), 0);
    chk("rst_read_data", read_data, 0);
    #14 rst = 1'b0;

    // we wd fl re wc lc rv push word
    tbl.push_back('{1, 8'h01, 0, 0, 0, 1, 0, 0, 0});
    tbl.push_back('{1, 8'h02, 0, 0, 0, 2, 0, 0, 0});
    tbl.push_back('{1, 8'h03, 0, 0, 0, 3, 0, 0, 0});
    tbl.push_back('{1, 8'h04, 0, 0, 1, 0, 0, 1, 32'h01020304});
    tbl.push_back('{1, 8'h05, 0, 0, 1, 1, 0, 0, 0});
    tbl.push_back('{1, 8'h06, 0, 0, 1, 2, 0, 0, 0});
    tbl.push_back('{1, 8'h07, 0, 0, 1, 3, 0, 0, 0});
    tbl.push_back('{1, 8'h08, 0, 0, 2, 0, 0, 1, 32'h05060708});
    tbl.push_back('{0, 8'h00, 0, 1, 1, 0, 1, 0, 0});
    tbl.push_back('{0, 8'h00, 0, 1, 0, 0, 1, 0, 0});
    tbl.push_back('{0, 8'h00, 0, 1, 0, 0, 0, 0, 0});
    tbl.push_back('{0, 8'h00, 1, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{1, 8'hAA, 0, 0, 0, 1, 0, 0, 0});
    tbl.push_back('{1, 8'hBB, 0, 0, 0, 2, 0, 0, 0});
    tbl.push_back('{0, 8'h00, 1, 0, 1, 0, 0, 1, 32'hAABB0000});
    tbl.push_back('{1, 8'hAA, 0, 0, 1, 1, 0, 0, 0});
    tbl.push_back('{1, 8'hBB, 0, 0, 1, 2, 0, 0, 0});
    tbl.push_back('{1, 8'hCC, 1, 0, 2, 0, 0, 1, 32'hAABBCC00});
    tbl.push_back('{1, 8'hD1, 0, 1, 1, 1, 1, 0, 0});
    tbl.push_back('{0, 8'h00, 0, 1, 0, 1, 1, 0, 0});
    tbl.push_back('{0, 8'h00, 1, 0, 1, 0, 0, 1, 32'hD1000000});
    tbl.push_back('{0, 8'h00, 0, 1, 0, 0, 1, 0, 0});

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].push) exp_q.push_back(tbl[i].word);
      step(tbl[i].we, tbl[i].wd, tbl[i].fl, tbl[i].re,
           tbl[i].wc, tbl[i].lc, tbl[i].rv);
    end

    // fill all four entries
    for (int i = 0; i < 16; i++) begin
      logic [7:0] b;
      b = 8'(8'h20 + i);
      if (i % 4 == 3)
        exp_q.push_back({b - 8'd3, b - 8'd2, b - 8'd1, b});
      step(1, b, 0, 0, (i + 1) / 4, (i + 1) % 4, 0);
    end
    // push while full with a read: element dropped
    step(1, 8'hFF, 0, 1, 3, 0, 1);
    exp_q.push_back(32'h55000000);
    step(1, 8'h55, 0, 0, 3, 1, 0);
    step(0, 8'h00, 1, 0, 4, 0, 0);
    // write and flush while full are ignored
    step(1, 8'h66, 1, 0, 4, 0, 0);
    step(0, 8'h00, 0, 1, 3, 0, 1);
    step(0, 8'h00, 0, 1, 2, 0, 1);
    step(0, 8'h00, 0, 1, 1, 0, 1);
    step(0, 8'h00, 0, 1, 0, 0, 1);

    // asynchronous reset mid-word
    step(1, 8'h91, 0, 0, 0, 1, 0);
    step(1, 8'h92, 0, 0, 0, 2, 0);
    step(1, 8'h93, 0, 0, 0, 3, 0);
    #2 rst = 1'b1;
    #1;
    chk("arst_lane_count", 32'(lane_count), 0);
    chk("arst_word_count", 32'(word_count), 0);
    chk("arst_empty", 32'(empty), 1);
    chk("arst_full", 32'(full), 0);
    chk("arst_read_valid", 32'(read_valid), 0);
    chk("arst_read_data", read_data, 0);
    #1 rst = 1'b0;
    last_rd = '0;
    step(1, 8'h11, 0, 0, 0, 1, 0);
    step(1, 8'h12, 0, 0, 0, 2, 0);
    step(1, 8'h13, 0, 0, 0, 3, 0);
    exp_q.push_back(32'h11121314);
    step(1, 8'h14, 0, 0, 1, 0, 0);
    step(0, 8'h00, 0, 1, 0, 0, 1);

    chk("leftover_words", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
